// File: rtl/wght_fetch_ctrl.sv
// Weight-store sequencer: streamed URAM load plus row fetch
// with a valid/ready word stream back to the neuron core.
module wght_fetch_ctrl #(
    parameter int RAM_DEPTH      = 10485,
    parameter int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH),
    parameter int WORDS_PER_ROW  = 8,
    parameter int NUM_ROWS       = RAM_DEPTH / WORDS_PER_ROW,
    parameter int ROW_WIDTH      = $clog2(NUM_ROWS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ld_clear,
    input  logic                      ld_valid,
    input  logic signed [63:0]        ld_data,
    output logic                      ld_wrap,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ROW_WIDTH-1:0]      req_row,
    output logic                      req_err,
    output logic                      w_valid,
    input  logic                      w_ready,
    output logic signed [63:0]        w_data,
    output logic                      w_last,
    output logic                      busy,
    output logic                      ren,
    output logic [RAM_ADDR_WIDTH-1:0] raddr,
    output logic                      wren,
    output logic [RAM_ADDR_WIDTH-1:0] wraddr,
    output logic signed [63:0]        wrdat,
    input  logic signed [63:0]        rdat
);

    localparam int CNT_W = $clog2(WORDS_PER_ROW + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_ROW - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_ROW);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [RAM_ADDR_WIDTH-1:0] PTR_MAX =
        RAM_ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [RAM_ADDR_WIDTH-1:0] PTR_ONE =
        RAM_ADDR_WIDTH'(1);
    localparam logic [RAM_ADDR_WIDTH-1:0] WPR_A =
        RAM_ADDR_WIDTH'(WORDS_PER_ROW);
    localparam logic [31:0] NUM_ROWS_U = NUM_ROWS;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t                    state_q;
    logic [RAM_ADDR_WIDTH-1:0] base_q;
    logic [RAM_ADDR_WIDTH-1:0] base_d;
    logic [CNT_W-1:0]          issue_cnt_q;
    logic                      w_valid_q;
    logic                      w_last_q;
    logic                      req_err_q;
    logic [RAM_ADDR_WIDTH-1:0] ld_ptr_q;
    logic                      ld_wrap_q;
    logic                      row_ok;

    // Loader owns the write port; it never waits on the fetch side.
    assign wren   = ld_valid;
    assign wrdat  = ld_data;
    assign wraddr = ld_ptr_q;
    assign ld_wrap = ld_wrap_q;

    // Load pointer: clear beats increment, wrap at the last URAM word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_ptr_q  <= '0;
            ld_wrap_q <= 1'b0;
        end else begin
            ld_wrap_q <= 1'b0;
            if (ld_clear) begin
                ld_ptr_q <= '0;
            end else if (ld_valid) begin
                if (ld_ptr_q == PTR_MAX) begin
                    ld_ptr_q  <= '0;
                    ld_wrap_q <= 1'b1;
                end else begin
                    ld_ptr_q <= ld_ptr_q + PTR_ONE;
                end
            end
        end
    end

    assign row_ok = (32'(req_row) < NUM_ROWS_U);
    assign base_d = RAM_ADDR_WIDTH'(req_row) * WPR_A;

    // Reads only issue when the output slot is free or draining, so
    // rdat (which holds while ren=0) doubles as the stall buffer.
    assign ren = (state_q == FETCH) && (issue_cnt_q < CNT_FULL)
               && (!w_valid_q || w_ready);
    assign raddr = base_q + RAM_ADDR_WIDTH'(issue_cnt_q);

    assign req_ready = (state_q == IDLE) && !w_valid_q;
    assign req_err   = req_err_q;
    assign w_valid   = w_valid_q;
    assign w_last    = w_last_q;
    assign w_data    = rdat;
    assign busy      = (state_q != IDLE) || w_valid_q;

    // Fetch sequencer with its registered stream flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            w_valid_q   <= 1'b0;
            w_last_q    <= 1'b0;
            req_err_q   <= 1'b0;
        end else begin
            req_err_q <= 1'b0;
            if (ren) begin
                w_valid_q   <= 1'b1;
                w_last_q    <= (issue_cnt_q == CNT_LAST);
                issue_cnt_q <= issue_cnt_q + CNT_ONE;
            end else if (w_ready) begin
                w_valid_q <= 1'b0;
                w_last_q  <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        if (row_ok) begin
                            state_q     <= FETCH;
                            base_q      <= base_d;
                            issue_cnt_q <= '0;
                        end else begin
                            req_err_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (w_valid_q && w_ready && w_last_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
